// File: rtl/hamming_uart_pkg.sv
// Shared definitions for the Hamming(7,4) UART link: FSM state encoding,
// frame-length constants and the (7,4) encode function. The receiver-side
// decoder imports this same package so both ends agree on bit ordering.
// Build option: HAMMING_TX_PARITY_EN adds an even-parity bit to each frame.
package hamming_uart_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

`ifdef HAMMING_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // start + codeword + optional parity + stop
  localparam int FRAME_BITS = 1 + CODE_W + PARITY_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Codeword layout: data bits sit at positions 2,4,5,6; positions 0,1,3
  // carry the check bits.
  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming_uart_tx_encoder.sv
// Combinational Hamming(7,4) encoder used by the transmitter at the
// moment a nibble is accepted.
module hamming_encoder_74
  import hamming_uart_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  assign o_code = hamming74_encode(i_data);

endmodule

// File: rtl/hamming_uart_tx.sv
// UART transmitter that sends one Hamming(7,4) codeword per frame:
// start bit, code[0]..code[6] LSB first, optional parity, stop bit.
// Build option: define HAMMING_TX_PARITY_EN to insert an even-parity bit
// over the codeword between the data bits and the stop bit.
module hamming_uart_tx
  import hamming_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic [CODE_W-1:0] code_out,
  output logic [2:0]        state_out,
  output logic              tx_done
);

  localparam logic [7:0] BIT_END  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(CODE_W - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_cnt;
  logic [7:0]        w_next_cnt;
  logic [2:0]        r_bit;
  logic [2:0]        w_next_bit;
  logic [2:0]        w_bit_inc;
  logic              r_tx;
  logic              w_next_tx;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_code;
  logic              w_xfer;
  logic              w_bit_end;

  assign in_ready  = (r_state == ST_IDLE) && ena && rst_n;
  assign w_xfer    = in_valid && in_ready;
  assign w_bit_end = (r_cnt == BIT_END);
  assign w_bit_inc = r_bit + 3'd1;

  // Combinational so that a frozen (ena low) block never reports completion.
  assign tx_done   = ena && (r_state == ST_STOP) && w_bit_end;
  assign tx        = r_tx;
  assign code_out  = r_code;
  assign state_out = r_state;

  hamming_encoder_74 u_encoder (
    .i_data (in_data),
    .o_code (w_code)
  );

  // Next-state, baud counter, bit index and next tx level.
  always_comb begin
    // NOTE: every output gets a hold value first so no path infers a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_bit   = r_bit;
    w_next_tx    = r_tx;
    if (ena) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            w_next_state = ST_START;
            w_next_cnt   = '0;
            w_next_bit   = '0;
            w_next_tx    = 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            w_next_state = ST_DATA;
            w_next_cnt   = '0;
            w_next_tx    = r_code[0];
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            w_next_cnt = '0;
            if (r_bit == LAST_BIT) begin
              w_next_bit = '0;
`ifdef HAMMING_TX_PARITY_EN
              w_next_state = ST_PARITY;
              w_next_tx    = ^r_code;
`else
              w_next_state = ST_STOP;
              w_next_tx    = 1'b1;
`endif
            end else begin
              w_next_bit = w_bit_inc;
              w_next_tx  = r_code[w_bit_inc];
            end
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            w_next_state = ST_STOP;
            w_next_cnt   = '0;
            w_next_tx    = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
            w_next_tx    = 1'b1;
          end else begin
            w_next_cnt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
          w_next_bit   = '0;
          w_next_tx    = 1'b1;
        end
      endcase
    end
  end

  // State register with the frame counters and the registered tx line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_bit   <= w_next_bit;
      r_tx    <= w_next_tx;
    end
  end

  // Capture the codeword only on a handshake so later input changes cannot
  // disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_code <= '0;
    end else if (w_xfer) begin
      r_code <= w_code;
    end
  end

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Self-checking bench for hamming_uart_tx with CLKS_PER_BIT=4.
// Define HAMMING_TX_PARITY_EN for both bench and RTL to check 10-bit frames.
module tb_hamming_uart_tx;

  localparam int CPB = 4;
`ifdef HAMMING_TX_PARITY_EN
  localparam int FRAME = 10;
`else
  localparam int FRAME = 9;
`endif
  localparam int FL = FRAME * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic [6:0] code_out;
  logic [2:0] state_out;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] code;
  } vec_t;

  vec_t vecs[9];

  hamming_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .code_out  (code_out),
    .state_out (state_out),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_state(input int b);
    if (b == 0) return 3'd1;
    if (b <= 7) return 3'd2;
    if (b == FRAME - 1) return 3'd4;
    return 3'd3;
  endfunction

  // Called just after a negedge; returns at the negedge of the tx_done cycle.
  task automatic run_frame(input logic [3:0] nib, input logic [6:0] code,
                           input int freeze_at, input int freeze_len);
    logic [FRAME-1:0] bits;
    int b;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 7; i++) bits[i+1] = code[i];
`ifdef HAMMING_TX_PARITY_EN
    bits[8] = ^code;
`endif
    in_data  = nib;
    in_valid = 1'b1;
    check($sformatf("in_ready before %h", nib), in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~nib;
    check($sformatf("code_out %h", nib), code_out, code);
    for (int n = 1; n <= FL; n++) begin
      b = (n - 1) / CPB;
      check($sformatf("tx %h n=%0d", nib, n), tx, bits[b]);
      check($sformatf("tx_done %h n=%0d", nib, n), tx_done, 32'(n == FL));
      check($sformatf("state %h n=%0d", nib, n), state_out, exp_state(b));
      if (n == freeze_at) begin
        ena = 1'b0;
        for (int k = 0; k < freeze_len; k++) begin
          @(negedge clk);
          check($sformatf("frozen tx k=%0d", k), tx, bits[b]);
          check($sformatf("frozen tx_done k=%0d", k), tx_done, 0);
          check($sformatf("frozen state k=%0d", k), state_out, exp_state(b));
        end
        ena = 1'b1;
      end
      if (n < FL) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_n;
    vecs = '{'{4'h0, 7'h00}, '{4'h1, 7'h07}, '{4'h2, 7'h19}, '{4'h4, 7'h2A},
             '{4'h8, 7'h4B}, '{4'h6, 7'h33}, '{4'hA, 7'h52}, '{4'hB, 7'h55},
             '{4'hF, 7'h7F}};

    // Reset, then idle with ena high.
    repeat (3) @(negedge clk);
    check("in_ready during reset", in_ready, 0);
    check("tx during reset", tx, 1);
    rst_n = 1'b1;
    #1;
    check("reset tx", tx, 1);
    check("reset in_ready", in_ready, 1);
    check("reset state", state_out, 0);
    check("reset code_out", code_out, 0);
    check("reset tx_done", tx_done, 0);

    // Table of nibbles, each sent with the minimum gap between frames.
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].nib, vecs[i].code, 0, 0);
      @(negedge clk);
      check($sformatf("idle after %h", vecs[i].nib), state_out, 0);
    end

    // ena low for 10 cycles in the middle of DATA bit 3.
    run_frame(4'hB, 7'h55, 18, 10);
    @(negedge clk);

    // Back-to-back frames with in_valid held high.
    in_data  = 4'h0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b first code", code_out, 7'h00);
    check("b2b first start", tx, 0);
    in_data = 4'hF;
    wait_n = 0;
    while (!tx_done && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check("b2b first done seen", tx_done, 1);
    check("b2b first done time", wait_n, FL - 1);
    @(negedge clk);
    check("b2b gap tx", tx, 1);
    check("b2b gap state", state_out, 0);
    @(negedge clk);
    check("b2b second start tx", tx, 0);
    check("b2b second state", state_out, 1);
    check("b2b second code", code_out, 7'h7F);
    in_valid = 1'b0;
    wait_n = 0;
    while (!tx_done && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check("b2b second done seen", tx_done, 1);
    @(negedge clk);

    // Reset pulse during DATA, then an immediate new frame.
    in_data  = 4'hB;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-reset state", state_out, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset tx", tx, 1);
    check("midreset state", state_out, 0);
    check("midreset code", code_out, 0);
    check("midreset tx_done", tx_done, 0);
    check("midreset in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", in_ready, 1);
    run_frame(4'h4, 7'h2A, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
